// File: rtl/param_fetch_unit.sv
// param_fetch_unit
// Reads the NUM_WORDS-word parameter SRAM after a start pulse, decodes the
// words into registered conv-layer fields, derives the output spatial
// dimensions, validates the layer and holds the result until finish.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start_i, finish_i     layer start (IDLE only) / layer done (READY/ERROR only)
//   cs_o, oe_o, addr_o    SRAM read port controls
//   W_req_o, W_data_o     SRAM write port, tied to write-disable / zero
//   R_data_i              SRAM read data, RD_LAT cycles after the address
//   busy_o                fetch/drain/check in progress
//   params_valid_o        fields valid (READY)
//   err_o, err_code_o     invalid layer (ERROR): 1 zero dim, 2 bad stride,
//                         3 kernel larger than padded input
//   *_o field outputs     decoded words 0..7 plus derived out_h_o/out_w_o
module param_fetch_unit #(
    parameter int unsigned NUM_WORDS = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              finish_i,
    output logic              cs_o,
    output logic              oe_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              W_req_o,
    output logic [DATA_W-1:0] W_data_o,
    input  logic [DATA_W-1:0] R_data_i,
    output logic              busy_o,
    output logic              params_valid_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [15:0]       in_h_o,
    output logic [15:0]       in_w_o,
    output logic [15:0]       in_c_o,
    output logic [15:0]       out_c_o,
    output logic [3:0]        kernel_o,
    output logic [3:0]        stride_o,
    output logic [3:0]        pad_o,
    output logic              relu_en_o,
    output logic              pool_en_o,
    output logic [31:0]       bias_base_o,
    output logic [31:0]       weight_base_o,
    output logic [31:0]       ifmap_base_o,
    output logic [31:0]       ofmap_base_o,
    output logic [4:0]        quant_shift_o,
    output logic [15:0]       out_h_o,
    output logic [15:0]       out_w_o
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_CHECK,
        S_READY,
        S_ERROR
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] words [NUM_WORDS];
    logic [RD_LAT-1:0] pipe_v;
    logic [IDX_W-1:0]  pipe_a [RD_LAT];

    // Write port is permanently disabled (active-low request held high).
    assign W_req_o  = 1'b1;
    assign W_data_o = '0;

    // Raw field views of the captured words
    logic [15:0] w_in_h, w_in_w, w_in_c, w_out_c;
    logic [3:0]  w_kernel, w_stride, w_pad;

    assign w_in_h   = words[0][15:0];
    assign w_in_w   = words[0][31:16];
    assign w_in_c   = words[1][15:0];
    assign w_out_c  = words[1][31:16];
    assign w_kernel = words[2][3:0];
    assign w_stride = words[2][7:4];
    assign w_pad    = words[2][11:8];

    logic unused_bits;
    assign unused_bits = ^{words[2][31:14], words[7][31:5]};

    // Validation and output-dimension derivation used in CHECK
    logic [16:0] ph_c, pw_c, dh_c, dw_c;
    logic [15:0] oh_c, ow_c;
    logic [1:0]  code_c;

    always_comb begin
        ph_c = {1'b0, w_in_h} + {12'd0, w_pad, 1'b0};
        pw_c = {1'b0, w_in_w} + {12'd0, w_pad, 1'b0};
        dh_c = ph_c - 17'(w_kernel);
        dw_c = pw_c - 17'(w_kernel);
        if (w_stride == 4'd2) begin
            dh_c = dh_c >> 1;
            dw_c = dw_c >> 1;
        end
        oh_c = 16'(dh_c + 17'd1);
        ow_c = 16'(dw_c + 17'd1);

        code_c = 2'd0;
        if (w_in_h == '0 || w_in_w == '0 || w_in_c == '0 || w_out_c == '0 || w_kernel == '0) begin
            code_c = 2'd1;
        end else if (w_stride != 4'd1 && w_stride != 4'd2) begin
            code_c = 2'd2;
        end else if (ph_c < 17'(w_kernel) || pw_c < 17'(w_kernel)) begin
            code_c = 2'd3;
        end
    end

    // Last word of the fetch has come out of the read pipe
    logic drain_done_c;
    assign drain_done_c = pipe_v[RD_LAT-1] && (pipe_a[RD_LAT-1] == LAST_IDX);

    // Next-state and next-output logic
    logic [ADDR_W-1:0] addr_n;
    logic              cs_n, valid_n, err_n, busy_n, load_c;
    logic [1:0]        code_n;

    always_comb begin
        state_n = state;
        addr_n  = '0;
        cs_n    = 1'b0;
        valid_n = params_valid_o;
        err_n   = err_o;
        code_n  = err_code_o;
        load_c  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_n = S_FETCH;
                    cs_n    = 1'b1;
                end
            end
            S_FETCH: begin
                cs_n = 1'b1;
                if (addr_o == LAST_ADDR) begin
                    state_n = S_DRAIN;
                    addr_n  = LAST_ADDR;
                end else begin
                    addr_n = addr_o + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_done_c) begin
                    state_n = S_CHECK;
                end else begin
                    cs_n   = 1'b1;
                    addr_n = LAST_ADDR;
                end
            end
            S_CHECK: begin
                load_c  = 1'b1;
                state_n = (code_c != 2'd0) ? S_ERROR : S_READY;
                valid_n = (code_c == 2'd0);
                err_n   = (code_c != 2'd0);
                code_n  = code_c;
            end
            S_READY, S_ERROR: begin
                if (finish_i) begin
                    state_n = S_IDLE;
                    valid_n = 1'b0;
                    err_n   = 1'b0;
                    code_n  = 2'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n == S_FETCH) || (state_n == S_DRAIN) || (state_n == S_CHECK);
    end

    // State and control output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            addr_o         <= '0;
            cs_o           <= 1'b0;
            oe_o           <= 1'b0;
            busy_o         <= 1'b0;
            params_valid_o <= 1'b0;
            err_o          <= 1'b0;
            err_code_o     <= 2'd0;
        end else begin
            state          <= state_n;
            addr_o         <= addr_n;
            cs_o           <= cs_n;
            oe_o           <= cs_n;
            busy_o         <= busy_n;
            params_valid_o <= valid_n;
            err_o          <= err_n;
            err_code_o     <= code_n;
        end
    end

    // Read pipe tracks which word each returning beat belongs to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) pipe_a[i] <= '0;
            for (int i = 0; i < int'(NUM_WORDS); i++) words[i] <= '0;
        end else begin
            pipe_v[0] <= (state == S_FETCH);
            pipe_a[0] <= IDX_W'(addr_o);
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_a[i] <= pipe_a[i-1];
            end
            if (pipe_v[RD_LAT-1]) begin
                words[pipe_a[RD_LAT-1]] <= R_data_i;
            end
        end
    end

    // Field outputs update only in CHECK and hold through READY/ERROR/IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_h_o        <= '0;
            in_w_o        <= '0;
            in_c_o        <= '0;
            out_c_o       <= '0;
            kernel_o      <= '0;
            stride_o      <= '0;
            pad_o         <= '0;
            relu_en_o     <= 1'b0;
            pool_en_o     <= 1'b0;
            bias_base_o   <= '0;
            weight_base_o <= '0;
            ifmap_base_o  <= '0;
            ofmap_base_o  <= '0;
            quant_shift_o <= '0;
            out_h_o       <= '0;
            out_w_o       <= '0;
        end else if (load_c) begin
            in_h_o        <= w_in_h;
            in_w_o        <= w_in_w;
            in_c_o        <= w_in_c;
            out_c_o       <= w_out_c;
            kernel_o      <= w_kernel;
            stride_o      <= w_stride;
            pad_o         <= w_pad;
            relu_en_o     <= words[2][12];
            pool_en_o     <= words[2][13];
            bias_base_o   <= words[3][31:0];
            weight_base_o <= words[4][31:0];
            ifmap_base_o  <= words[5][31:0];
            ofmap_base_o  <= words[6][31:0];
            quant_shift_o <= words[7][4:0];
            out_h_o       <= (code_c == 2'd0) ? oh_c : 16'd0;
            out_w_o       <= (code_c == 2'd0) ? ow_c : 16'd0;
        end
    end

endmodule

// File: tb/tb_param_fetch_unit.sv
// Testbench for param_fetch_unit: SRAM model, behavioural reference model,
// per-cycle compare process and directed layer scenarios.
module tb_param_fetch_unit;

    localparam int NW = 8;
    localparam int RL = 1;

    logic        clk = 1'b0;
    logic        rst, start_i, finish_i;
    logic        cs_o, oe_o, W_req_o;
    logic [31:0] addr_o, W_data_o, R_data_i;
    logic        busy_o, params_valid_o, err_o;
    logic [1:0]  err_code_o;
    logic [15:0] in_h_o, in_w_o, in_c_o, out_c_o, out_h_o, out_w_o;
    logic [3:0]  kernel_o, stride_o, pad_o;
    logic        relu_en_o, pool_en_o;
    logic [31:0] bias_base_o, weight_base_o, ifmap_base_o, ofmap_base_o;
    logic [4:0]  quant_shift_o;

    always #5 clk = ~clk;

    param_fetch_unit dut (
        .clk(clk), .rst(rst), .start_i(start_i), .finish_i(finish_i),
        .cs_o(cs_o), .oe_o(oe_o), .addr_o(addr_o), .W_req_o(W_req_o),
        .W_data_o(W_data_o), .R_data_i(R_data_i), .busy_o(busy_o),
        .params_valid_o(params_valid_o), .err_o(err_o), .err_code_o(err_code_o),
        .in_h_o(in_h_o), .in_w_o(in_w_o), .in_c_o(in_c_o), .out_c_o(out_c_o),
        .kernel_o(kernel_o), .stride_o(stride_o), .pad_o(pad_o),
        .relu_en_o(relu_en_o), .pool_en_o(pool_en_o),
        .bias_base_o(bias_base_o), .weight_base_o(weight_base_o),
        .ifmap_base_o(ifmap_base_o), .ofmap_base_o(ofmap_base_o),
        .quant_shift_o(quant_shift_o), .out_h_o(out_h_o), .out_w_o(out_w_o)
    );

    // Parameter SRAM, one-cycle read latency
    logic [31:0] mem [NW];
    always @(posedge clk) begin
        if (cs_o && oe_o) R_data_i <= mem[addr_o[2:0]];
    end

    int nvec = 0;
    int nmis = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: cycles since accepted start, plus snapshot of the words
    int          t;
    bit          done;
    logic [31:0] fw [NW];
    logic        e_valid, e_err;
    logic [1:0]  e_code;

    function automatic int exp_code();
        int k, s, ph, pw;
        k  = int'(fw[2][3:0]);
        s  = int'(fw[2][7:4]);
        ph = int'(fw[0][15:0]) + 2 * int'(fw[2][11:8]);
        pw = int'(fw[0][31:16]) + 2 * int'(fw[2][11:8]);
        if (fw[0][15:0] == 0 || fw[0][31:16] == 0 || fw[1][15:0] == 0 ||
            fw[1][31:16] == 0 || k == 0) return 1;
        if (s != 1 && s != 2) return 2;
        if (ph < k || pw < k) return 3;
        return 0;
    endfunction

    function automatic logic [15:0] exp_dim(input logic [15:0] in_dim);
        int p;
        if (exp_code() != 0) return 16'd0;
        p = int'(in_dim) + 2 * int'(fw[2][11:8]);
        return 16'((p - int'(fw[2][3:0])) / int'(fw[2][7:4]) + 1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t = -1; done = 0; e_valid = 0; e_err = 0; e_code = 0;
            for (int i = 0; i < NW; i++) fw[i] = '0;
        end else if (done) begin
            if (finish_i) begin
                done = 0; e_valid = 0; e_err = 0; e_code = 0;
            end
        end else if (t < 0) begin
            if (start_i) t = 0;
        end else begin
            t++;
            if (t == NW + RL + 1) begin
                for (int i = 0; i < NW; i++) fw[i] = mem[i];
                e_code  = 2'(exp_code());
                e_err   = (e_code != 0);
                e_valid = (e_code == 0);
                done    = 1;
                t       = -1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            bit fe;
            int ea;
            fe = (t >= 0) && (t < NW + RL);
            ea = (t >= 0 && t < NW) ? t : (fe ? NW - 1 : 0);
            chk("w_req", W_req_o, 1);
            chk("w_data", W_data_o, 0);
            chk("cs", cs_o, fe);
            chk("oe", oe_o, fe);
            chk("addr", addr_o, ea);
            chk("busy", busy_o, (t >= 0));
            chk("valid", params_valid_o, e_valid);
            chk("err", err_o, e_err);
            chk("err_code", err_code_o, e_code);
            chk("in_h", in_h_o, fw[0][15:0]);
            chk("in_w", in_w_o, fw[0][31:16]);
            chk("in_c", in_c_o, fw[1][15:0]);
            chk("out_c", out_c_o, fw[1][31:16]);
            chk("kernel", kernel_o, fw[2][3:0]);
            chk("stride", stride_o, fw[2][7:4]);
            chk("pad", pad_o, fw[2][11:8]);
            chk("relu", relu_en_o, fw[2][12]);
            chk("pool", pool_en_o, fw[2][13]);
            chk("bias", bias_base_o, fw[3]);
            chk("weight", weight_base_o, fw[4]);
            chk("ifmap", ifmap_base_o, fw[5]);
            chk("ofmap", ofmap_base_o, fw[6]);
            chk("qshift", quant_shift_o, fw[7][4:0]);
            chk("out_h", out_h_o, exp_dim(fw[0][15:0]));
            chk("out_w", out_w_o, exp_dim(fw[0][31:16]));
        end
    end

    task automatic load_words(input logic [31:0] w0, input logic [31:0] w2);
        mem[0] = w0;    mem[1] = 32'h0010_0008; mem[2] = w2;    mem[3] = 32'h100;
        mem[4] = 32'h200; mem[5] = 32'h300;     mem[6] = 32'h400; mem[7] = 32'h7;
    endtask

    // Start a layer and wait (bounded) for READY or ERROR; returns latency
    task automatic run_layer(input bit pulse, output int lat);
        bit seen;
        seen = 0;
        lat  = -1;
        @(negedge clk) start_i = 1;
        @(negedge clk) start_i = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (pulse) start_i = (n == 3);
            if (n < NW) chk("addr_step", addr_o, n);
            if (params_valid_o || err_o) begin
                seen = 1;
                lat  = n;
            end
        end
        start_i = 0;
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic do_finish();
        @(negedge clk) finish_i = 1;
        @(negedge clk) finish_i = 0;
    endtask

    initial begin
        int lat;
        rst = 0; start_i = 0; finish_i = 0;
        load_words(32'h0020_0020, 32'h0000_1113);
        #3 rst = 1;
        #1 chk_en = 1;
        repeat (2) @(negedge clk);
        #2 rst = 0;
        @(negedge clk);
        chk("rst_valid", params_valid_o, 0);
        chk("rst_busy", busy_o, 0);

        // Nominal layer: 3x3, stride 1, pad 1 on 32x32
        run_layer(0, lat);
        chk("latency", lat, 10);
        chk("t1_kernel", kernel_o, 3);
        chk("t1_stride", stride_o, 1);
        chk("t1_pad", pad_o, 1);
        chk("t1_relu", relu_en_o, 1);
        chk("t1_out_h", out_h_o, 32);
        chk("t1_out_w", out_w_o, 32);
        chk("t1_qshift", quant_shift_o, 7);
        chk("t1_in_c", in_c_o, 8);
        chk("t1_out_c", out_c_o, 16);
        // start in READY is ignored
        @(negedge clk) start_i = 1;
        @(negedge clk) start_i = 0;
        chk("t1_ready_hold", params_valid_o, 1);
        chk("t1_no_busy", busy_o, 0);
        do_finish();
        chk("t1_released", params_valid_o, 0);

        // Stride 2, with a start pulse during FETCH
        load_words(32'h0020_0020, 32'h0000_0123);
        run_layer(1, lat);
        chk("t2_latency", lat, 10);
        chk("t2_out_h", out_h_o, 16);
        chk("t2_out_w", out_w_o, 16);
        do_finish();

        // Stride 3 -> bad stride
        load_words(32'h0020_0020, 32'h0000_0133);
        run_layer(0, lat);
        chk("t3_err", err_o, 1);
        chk("t3_code", err_code_o, 2);
        chk("t3_valid", params_valid_o, 0);
        chk("t3_out_h", out_h_o, 0);
        do_finish();
        chk("t3_err_clr", err_o, 0);
        chk("t3_idle", busy_o, 0);

        // Zero dimension
        load_words(32'h0000_0000, 32'h0000_1113);
        run_layer(0, lat);
        chk("t4_code", err_code_o, 1);
        do_finish();

        // in_h=2, pad 0, kernel 5 -> kernel exceeds padded input
        load_words(32'h0020_0002, 32'h0000_0015);
        run_layer(0, lat);
        chk("t5_code", err_code_o, 3);
        do_finish();

        // Reset in the 4th FETCH cycle, then a clean refetch
        load_words(32'h0020_0020, 32'h0000_1113);
        @(negedge clk) start_i = 1;
        @(negedge clk) start_i = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1;
        @(negedge clk);
        chk("t6_cs", cs_o, 0);
        chk("t6_addr", addr_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_in_h", in_h_o, 0);
        chk("t6_err_code", err_code_o, 0);
        #2 rst = 0;
        run_layer(0, lat);
        chk("t6_latency", lat, 10);
        chk("t6_out_h", out_h_o, 32);
        chk("t6_in_h", in_h_o, 32);

        // start and finish together in READY: back to IDLE, no new fetch
        @(negedge clk) begin start_i = 1; finish_i = 1; end
        @(negedge clk) begin start_i = 0; finish_i = 0; end
        chk("t7_valid", params_valid_o, 0);
        chk("t7_busy", busy_o, 0);
        @(negedge clk);
        chk("t7_no_fetch", cs_o, 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/param_fetch_unit.md
Name: param_fetch_unit

Overview:
- EPU-side consumer of the 8-word parameter SRAM (16B-addressed param buffer). Sits directly downstream of the parameter buffer wrapper on its EPU-facing SRAM port.
- On start it sequentially reads all 8 parameter words, decodes them into registered convolution-layer fields, and derives output spatial dimensions.
- Validates the fields, then presents them to the conv datapath with a valid/error flag until the layer finishes.

Parameters:
- NUM_WORDS, 8, parameter words fetched (addresses 0..NUM_WORDS-1).
- DATA_W, 32, SRAM data width.
- ADDR_W, 32, SRAM address width.
- RD_LAT, 1, SRAM read latency in cycles (R_data valid RD_LAT cycles after the address is issued).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  layer start; sampled only in IDLE.
- finish_i  in  1  layer finished; releases parameters (READY/ERROR -> IDLE).
- cs_o  out  1  SRAM chip select.
- oe_o  out  1  SRAM output enable.
- addr_o  out  ADDR_W  SRAM word address.
- W_req_o  out  1  SRAM write request; constant write-disable encoding.
- W_data_o  out  DATA_W  constant 0.
- R_data_i  in  DATA_W  SRAM read data.
- busy_o  out  1  high in FETCH/DRAIN/CHECK.
- params_valid_o  out  1  high in READY.
- err_o  out  1  high in ERROR.
- err_code_o  out  2  1=zero dim, 2=bad stride, 3=kernel > padded input; 0 otherwise.
- in_h_o, in_w_o, in_c_o, out_c_o  out  16 each  word0[15:0], word0[31:16], word1[15:0], word1[31:16].
- kernel_o  out  4  word2[3:0].
- stride_o  out  4  word2[7:4].
- pad_o  out  4  word2[11:8].
- relu_en_o, pool_en_o  out  1 each  word2[12], word2[13].
- bias_base_o, weight_base_o, ifmap_base_o, ofmap_base_o  out  32 each  words 3..6.
- quant_shift_o  out  5  word7[4:0].
- out_h_o, out_w_o  out  16 each  derived output dimensions.

Behaviour:
- Reset (any time, including mid-fetch): state IDLE; every output and internal word register = 0; W_req_o = write-disable.
- States: IDLE, FETCH, DRAIN, CHECK, READY, ERROR.
- IDLE: cs_o=oe_o=0, addr_o=0. start_i=1 -> FETCH, address counter cleared.
- FETCH: cs_o=oe_o=1, addr_o=counter, counter +1 per cycle. After issuing address NUM_WORDS-1 -> DRAIN. Exactly NUM_WORDS consecutive cycles, no gaps.
- Capture: the word issued at cycle t is written into word register [addr] at cycle t+RD_LAT via an RD_LAT-deep address/valid pipe.
- DRAIN: cs_o=oe_o=1 with addr_o held at NUM_WORDS-1 for RD_LAT cycles until the last capture, then -> CHECK.
- CHECK (1 cycle): compute derived fields, register them, select the next state:
  - ph = in_h + 2*pad and pw = in_w + 2*pad, both 17-bit unsigned.
  - Error priority 1 (zero dim): in_h, in_w, in_c, out_c or kernel == 0.
  - Error priority 2 (bad stride): stride not in {1,2}.
  - Error priority 3 (kernel > padded input): ph < kernel or pw < kernel.
  - No error: out_h = ((ph - kernel) >> (stride-1)) + 1, truncated to 16 bits; out_w likewise. -> READY.
  - Any error: -> ERROR, out_h_o = out_w_o = 0.
- Total start-to-READY latency = NUM_WORDS + RD_LAT + 1 cycles (10 at defaults). params_valid_o rises on the cycle after CHECK.
- READY and ERROR: cs_o=oe_o=0. All field outputs held stable. finish_i=1 -> IDLE and, in the same edge, clears params_valid_o, err_o and err_code_o. Field outputs keep their values until the next CHECK.
- start_i outside IDLE: ignored. finish_i outside READY/ERROR: ignored.
- start_i and finish_i together in READY: finish_i wins -> IDLE. start_i is not remembered.
- The unit never writes the SRAM.

Test Plan:
- Reset, then start with words {0x0020_0020, 0x0010_0008, 0x0000_1113, 0x100, 0x200, 0x300, 0x400, 0x7} -> addr_o steps 0..7 over 8 cycles; params_valid_o rises 10 cycles after start; kernel=3, stride=1, pad=1, relu=1, out_h=out_w=32, quant_shift=7.
- Same input with word2=0x0000_0123 (stride 2, pad 1, kernel 3) -> out_h=out_w=16.
- word2 stride=3 -> err_o=1, err_code_o=2, params_valid_o=0, out_h_o=0; finish_i -> err_o=0, IDLE.
- word0=0 -> err_code_o=1. in_h=2, pad=0, kernel=5 -> err_code_o=3.
- Assert rst in the 4th FETCH cycle -> all outputs 0 next cycle; a following start performs a full clean 8-word fetch with correct fields.
- start_i pulses during FETCH and during READY -> ignored. start_i+finish_i together in READY -> IDLE with no new fetch. Check W_req_o is write-disable on every cycle.
